// File: rtl/hall_call_queue_pkg.sv
// Shared call codes, button indices, directions and FSM states
// for the hall-call queue and its selector.
package hall_call_queue_pkg;

  localparam logic [2:0] NO_CALL = 3'b000;
  localparam logic [2:0] C_1U = 3'b001;
  localparam logic [2:0] C_2U = 3'b010;
  localparam logic [2:0] C_3U = 3'b011;
  localparam logic [2:0] C_2D = 3'b110;
  localparam logic [2:0] C_3D = 3'b111;
  localparam logic [2:0] C_4D = 3'b100;

  localparam int B_1U = 0;
  localparam int B_2U = 1;
  localparam int B_3U = 2;
  localparam int B_2D = 3;
  localparam int B_3D = 4;
  localparam int B_4D = 5;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    IDLE, SELECT, ISSUE, CLEAR
  } state_e;

  function automatic logic [2:0] code_of(
    input logic [2:0] idx
  );
    case (idx)
      3'd0:    code_of = C_1U;
      3'd1:    code_of = C_2U;
      3'd2:    code_of = C_3U;
      3'd3:    code_of = C_2D;
      3'd4:    code_of = C_3D;
      3'd5:    code_of = C_4D;
      default: code_of = NO_CALL;
    endcase
  endfunction

  // floor code 00 is F4, so never compare raw bits
  function automatic logic [2:0] ord_of(
    input logic [1:0] f
  );
    return (f == 2'b00) ? 3'd4 : {1'b0, f};
  endfunction

  function automatic logic dir_of(
    input logic [2:0] idx
  );
    logic [2:0] c;
    c = code_of(idx);
    return c[2];
  endfunction

  function automatic logic [2:0] flr_of(
    input logic [2:0] idx
  );
    logic [2:0] c;
    c = code_of(idx);
    return ord_of(c[1:0]);
  endfunction

endpackage

// File: rtl/hall_call_queue_if.sv
// Button / lift-status / call-output bundle between the
// hall-call queue and its environment.
interface hall_call_queue_if;
  logic [5:0] btn;
  logic [1:0] lift_floor;
  logic       arrive;
  logic [2:0] call_out;
  logic       call_vld;
  logic [5:0] pending;
  logic       timeout_err;

  modport master (
    output btn, lift_floor, arrive,
    input  call_out, call_vld, pending, timeout_err
  );

  modport slave (
    input  btn, lift_floor, arrive,
    output call_out, call_vld, pending, timeout_err
  );
endinterface

// File: rtl/hall_call_queue_sel.sv
// SCAN picker: nearest call in sweep dir, then opposite dir,
// then lowest pending index. dir reports the pass that hit.
module hall_call_queue_sel
  import hall_call_queue_pkg::*;
(
  input  logic [5:0] pend,
  input  logic [1:0] lift_floor,
  input  logic       sweep,
  output logic [2:0] idx,
  output logic       dir,
  output logic       found
);

  function automatic logic [3:0] nearest(
    input logic [5:0] m,
    input logic [2:0] lo
  );
    logic [3:0] r;
    logic [2:0] best;
    logic [2:0] d;
    logic [2:0] fo;
    r    = '0;
    best = 3'd7;
    for (int i = 0; i < 6; i++) begin
      fo = flr_of(3'(i));
      d  = (fo > lo) ? fo - lo : lo - fo;
      if (m[i] && d < best) begin
        best = d;
        r    = {1'b1, 3'(i)};
      end
    end
    return r;
  endfunction

  logic [2:0] lo;
  logic [5:0] up_m, dn_m;
  logic [3:0] up_r, dn_r, first_r, second_r, any_r;

  always_comb begin
    lo   = ord_of(lift_floor);
    up_m = '0;
    dn_m = '0;
    for (int i = 0; i < 6; i++) begin
      up_m[i] = pend[i] &&
        ((dir_of(3'(i)) == DIR_UP &&
          flr_of(3'(i)) >= lo) || i == B_4D);
      dn_m[i] = pend[i] &&
        ((dir_of(3'(i)) == DIR_DOWN &&
          flr_of(3'(i)) <= lo) || i == B_1U);
    end
    up_r = nearest(up_m, lo);
    dn_r = nearest(dn_m, lo);
    first_r  = (sweep == DIR_UP) ? up_r : dn_r;
    second_r = (sweep == DIR_UP) ? dn_r : up_r;
    any_r = '0;
    for (int i = 5; i >= 0; i--) begin
      if (pend[i]) any_r = {1'b1, 3'(i)};
    end
  end

  always_comb begin
    idx   = '0;
    dir   = sweep;
    found = 1'b0;
    if (first_r[3]) begin
      idx   = first_r[2:0];
      found = 1'b1;
    end else if (second_r[3]) begin
      idx   = second_r[2:0];
      dir   = ~sweep;
      found = 1'b1;
    end else if (any_r[3]) begin
      idx   = any_r[2:0];
      dir   = dir_of(any_r[2:0]);
      found = 1'b1;
    end
  end

endmodule

// File: rtl/hall_call_queue.sv
// Hall-call latch + SCAN issue FSM feeding the lift controller.
// Define CALL_TIMEOUT_EN to drop calls left unserved too long.
module hall_call_queue
  import hall_call_queue_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256,
  parameter int TO_W        = 8
) (
  input logic               clk,
  input logic               rst_n,
  hall_call_queue_if.slave  bus
);

  if (2 ** TO_W < TIMEOUT_CYC) begin : g_bad_to_w
    $error("TO_W too narrow for TIMEOUT_CYC");
  end

  state_e     state_q, state_d;
  logic [5:0] pend_q, pend_d;
  logic [2:0] call_out_q, call_out_d;
  logic       call_vld_q, call_vld_d;
  logic       sweep_q, sweep_d;
  logic       scan_q, scan_d;
  logic [2:0] idx_q, idx_d;
  logic       err_q, err_d;

  logic [5:0] clr_m;
  logic       clr_dir;
  logic       hit;
  logic       to_fire;
  logic [2:0] sel_idx;
  logic       sel_dir;
  logic       sel_found;

  hall_call_queue_sel u_sel (
    .pend       (pend_q),
    .lift_floor (bus.lift_floor),
    .sweep      (sweep_q),
    .idx        (sel_idx),
    .dir        (sel_dir),
    .found      (sel_found)
  );

  // while issuing, arrivals clear in the direction being served
  always_comb begin
    clr_dir = (state_q == ISSUE) ? scan_q : sweep_q;
    clr_m   = '0;
    if (bus.arrive) begin
      case (bus.lift_floor)
        2'b01:   clr_m[B_1U] = 1'b1;
        2'b10:   clr_m[clr_dir ? B_2D : B_2U] = 1'b1;
        2'b11:   clr_m[clr_dir ? B_3D : B_3U] = 1'b1;
        default: clr_m[B_4D] = 1'b1;
      endcase
    end
  end

  assign hit = (state_q == ISSUE) && clr_m[idx_q];

`ifdef CALL_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (state_q == SELECT) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign to_fire = (state_q == ISSUE) && !hit &&
                   (cnt_q == TO_W'(TIMEOUT_CYC - 1));
`else
  assign to_fire = 1'b0;
`endif

  always_comb begin
    pend_d     = (pend_q | bus.btn) & ~clr_m;
    state_d    = state_q;
    call_out_d = call_out_q;
    call_vld_d = call_vld_q;
    sweep_d    = sweep_q;
    scan_d     = scan_q;
    idx_d      = idx_q;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_q != '0) state_d = SELECT;
      end
      SELECT: begin
        if (sel_found) begin
          call_out_d = code_of(sel_idx);
          call_vld_d = 1'b1;
          idx_d      = sel_idx;
          scan_d     = sel_dir;
          state_d    = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (hit || to_fire) begin
          call_out_d = NO_CALL;
          call_vld_d = 1'b0;
          state_d    = CLEAR;
        end
        if (to_fire) begin
          pend_d[idx_q] = 1'b0;
          err_d         = 1'b1;
        end
      end
      default: begin
        if (!err_q) sweep_d = dir_of(idx_q);
        state_d = (pend_q != '0) ? SELECT : IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      call_out_q <= NO_CALL;
      call_vld_q <= 1'b0;
      sweep_q    <= DIR_UP;
      scan_q     <= DIR_UP;
      idx_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      call_out_q <= call_out_d;
      call_vld_q <= call_vld_d;
      sweep_q    <= sweep_d;
      scan_q     <= scan_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
    end
  end

  assign bus.call_out    = call_out_q;
  assign bus.call_vld    = call_vld_q;
  assign bus.pending     = pend_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_hall_call_queue.sv
// Bench for hall_call_queue: issued calls checked against a
// queue of expected codes; state checks inline per scenario.
module tb_hall_call_queue;
  import hall_call_queue_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int total = 0;
  int bad = 0;
  logic [2:0] exp_q[$];
  logic [2:0] mon_e;
  logic vld_prev = 1'b0;

  hall_call_queue_if bus();

  hall_call_queue #(
    .TIMEOUT_CYC (16),
    .TO_W        (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1, "watchdog");
  end

  // scoreboard: every rising call_vld pops one expected code
  always @(posedge clk) begin
    #1;
    if (bus.call_vld === 1'b1 && vld_prev === 1'b0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_issue: got %b, none expected",
                 bus.call_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.call_out !== mon_e) begin
          bad++;
          $display("FAIL sb_issue: got %b want %b",
                   bus.call_out, mon_e);
        end
      end
    end
    vld_prev = bus.call_vld;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [5:0] b);
    bus.btn = b;
    cyc(1);
    bus.btn = '0;
  endtask

  task automatic arrive_at(input logic [1:0] f);
    bus.lift_floor = f;
    bus.arrive = 1'b1;
    cyc(1);
    bus.arrive = 1'b0;
  endtask

  task automatic wait_vld(input string nm);
    int n = 0;
    while (bus.call_vld !== 1'b1 && n < 20) begin
      cyc(1);
      n++;
    end
    total++;
    if (bus.call_vld !== 1'b1) begin
      bad++;
      $display("FAIL %s: call_vld got %b want 1",
               nm, bus.call_vld);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.btn = '0;
    bus.arrive = 1'b0;
    bus.lift_floor = 2'b01;
    cyc(2);
    total++;
    if (bus.call_out !== 3'b000 || bus.call_vld !== 1'b0 ||
        bus.pending !== 6'b0 || bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL reset: out=%b vld=%b pend=%b err=%b want 000 0 0 0",
               bus.call_out, bus.call_vld, bus.pending,
               bus.timeout_err);
    end
    rst_n = 1'b1;
    cyc(4);
    total++;
    if (bus.call_vld !== 1'b0 || bus.pending !== 6'b0) begin
      bad++;
      $display("FAIL reset_idle: vld=%b pend=%b want 0 0",
               bus.call_vld, bus.pending);
    end
  endtask

  task automatic test_latency;
    bus.lift_floor = 2'b01;
    exp_q.push_back(C_1U);
    press(6'b000001);
    total++;
    if (bus.pending !== 6'b000001 || bus.call_vld !== 1'b0) begin
      bad++;
      $display("FAIL lat_k: pend=%b vld=%b want 000001 0",
               bus.pending, bus.call_vld);
    end
    cyc(1);
    total++;
    if (bus.call_vld !== 1'b0) begin
      bad++;
      $display("FAIL lat_k1: vld=%b want 0", bus.call_vld);
    end
    cyc(1);
    total++;
    if (bus.call_vld !== 1'b1 || bus.call_out !== C_1U) begin
      bad++;
      $display("FAIL lat_k2: vld=%b out=%b want 1 001",
               bus.call_vld, bus.call_out);
    end
    arrive_at(2'b01);
    total++;
    if (bus.call_vld !== 1'b0 || bus.call_out !== NO_CALL ||
        bus.pending !== 6'b0) begin
      bad++;
      $display("FAIL lat_clear: vld=%b out=%b pend=%b want 0 000 0",
               bus.call_vld, bus.call_out, bus.pending);
    end
    cyc(3);
    total++;
    if (bus.call_vld !== 1'b0) begin
      bad++;
      $display("FAIL lat_idle: vld=%b want 0", bus.call_vld);
    end
  endtask

  task automatic test_scan;
    bus.lift_floor = 2'b10;
    exp_q.push_back(C_3U);
    exp_q.push_back(C_2D);
    exp_q.push_back(C_1U);
    press(6'b001101);
    total++;
    if (bus.pending !== 6'b001101) begin
      bad++;
      $display("FAIL scan_pend: got %b want 001101", bus.pending);
    end
    wait_vld("scan_3u");
    cyc(2);
    arrive_at(2'b11);
    total++;
    if (bus.pending !== 6'b001001) begin
      bad++;
      $display("FAIL scan_clr3u: pend=%b want 001001",
               bus.pending);
    end
    wait_vld("scan_2d");
    arrive_at(2'b10);
    total++;
    if (bus.pending !== 6'b000001) begin
      bad++;
      $display("FAIL scan_clr2d: pend=%b want 000001",
               bus.pending);
    end
    wait_vld("scan_1u");
    arrive_at(2'b01);
    cyc(3);
    total++;
    if (bus.pending !== 6'b0 || bus.call_vld !== 1'b0) begin
      bad++;
      $display("FAIL scan_end: pend=%b vld=%b want 0 0",
               bus.pending, bus.call_vld);
    end
  endtask

  task automatic test_collide;
    bus.btn = 6'b000010;
    arrive_at(2'b10);
    bus.btn = '0;
    total++;
    if (bus.pending !== 6'b0) begin
      bad++;
      $display("FAIL col_btn_clr: pend=%b want 000000",
               bus.pending);
    end
    cyc(3);
    total++;
    if (bus.call_vld !== 1'b0) begin
      bad++;
      $display("FAIL col_no_call: vld=%b want 0", bus.call_vld);
    end
    bus.lift_floor = 2'b00;
    exp_q.push_back(C_4D);
    press(6'b100100);
    wait_vld("col_4d");
    arrive_at(2'b11);
    total++;
    if (bus.pending !== 6'b100000 || bus.call_out !== C_4D ||
        bus.call_vld !== 1'b1) begin
      bad++;
      $display("FAIL col_3u_only: pend=%b out=%b vld=%b want 100000 100 1",
               bus.pending, bus.call_out, bus.call_vld);
    end
    arrive_at(2'b00);
    total++;
    if (bus.pending !== 6'b0 || bus.call_vld !== 1'b0) begin
      bad++;
      $display("FAIL col_4d_clr: pend=%b vld=%b want 0 0",
               bus.pending, bus.call_vld);
    end
    cyc(3);
  endtask

  task automatic test_reset_mid;
    bus.lift_floor = 2'b01;
    exp_q.push_back(C_2U);
    press(6'b011110);
    wait_vld("rm_2u");
    rst_n = 1'b0;
    cyc(1);
    total++;
    if (bus.call_out !== NO_CALL || bus.call_vld !== 1'b0 ||
        bus.pending !== 6'b0 || bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL rm_reset: out=%b vld=%b pend=%b err=%b want 000 0 0 0",
               bus.call_out, bus.call_vld, bus.pending,
               bus.timeout_err);
    end
    rst_n = 1'b1;
    cyc(1);
    exp_q.push_back(C_4D);
    press(6'b100000);
    wait_vld("rm_4d");
    total++;
    if (bus.call_out !== C_4D) begin
      bad++;
      $display("FAIL rm_4d: out=%b want 100", bus.call_out);
    end
    arrive_at(2'b00);
    cyc(3);
  endtask

  task automatic test_timeout;
    int n;
    bit seen;
    bus.lift_floor = 2'b01;
    exp_q.push_back(C_2U);
    exp_q.push_back(C_3U);
    press(6'b000110);
    wait_vld("to_2u");
`ifdef CALL_TIMEOUT_EN
    n = 0;
    while (bus.timeout_err !== 1'b1 && n < 40) begin
      cyc(1);
      n++;
    end
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL to_delay: err after %0d cycles want 16", n);
    end
    total++;
    if (bus.pending !== 6'b000100 || bus.call_vld !== 1'b0) begin
      bad++;
      $display("FAIL to_drop: pend=%b vld=%b want 000100 0",
               bus.pending, bus.call_vld);
    end
    cyc(1);
    total++;
    if (bus.timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL to_pulse: err=%b want 0", bus.timeout_err);
    end
`else
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (bus.timeout_err !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen || bus.call_vld !== 1'b1 || bus.call_out !== C_2U) begin
      bad++;
      $display("FAIL to_none: err_seen=%b vld=%b out=%b want 0 1 010",
               seen, bus.call_vld, bus.call_out);
    end
    arrive_at(2'b10);
`endif
    wait_vld("to_3u");
    arrive_at(2'b11);
    cyc(3);
  endtask

  initial begin
    test_reset;
    test_latency;
    test_scan;
    test_collide;
    test_reset_mid;
    test_timeout;
    cyc(2);
    total++;
    if (exp_q.size() != 0 || bus.pending !== 6'b0) begin
      bad++;
      $display("FAIL end: left=%0d pend=%b want 0 000000",
               exp_q.size(), bus.pending);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
